// File: rtl/req_pending_latch.sv
// Sticky request latch feeding a priority encoder; grant registered under valid/ready, served bit retired.
// Latency: req_in -> pend_req next cycle -> gnt_valid the cycle after; grant held while gnt_ready is low.
module req_pending_latch #(
   parameter int N    = 8,
   parameter int IDXW = $clog2(N),
   parameter int CNTW = 8
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_flush,
   input  logic [N-1:0]    i_req_in,
   output logic [N-1:0]    o_pend_req,
   input  logic [IDXW-1:0] i_enc_in,
   input  logic            i_enc_valid,
   output logic            o_gnt_valid,
   output logic [IDXW-1:0] o_gnt_idx,
   input  logic            i_gnt_ready,
   output logic            o_busy,
   output logic [CNTW-1:0] o_drop_cnt,
   output logic            o_err
);

   localparam int            PCW  = $clog2(N + 1);
   localparam int            SW   = ((CNTW > PCW) ? CNTW : PCW) + 1;
   localparam logic [IDXW:0] LP_N = (IDXW + 1)'(N);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t          r_state;
   logic [N-1:0]    r_pend;
   logic            r_gnt_vld;
   logic [IDXW-1:0] r_gnt_idx;
   logic [CNTW-1:0] r_drop_cnt;
   logic            r_err;

   logic            w_handshake;
   logic            w_window;
   logic            w_in_range;
   logic            w_is_pend;
   logic            w_capture;
   logic            w_bad_enc;
   logic [N-1:0]    w_clr;
   logic [N-1:0]    w_kept;
   logic [N-1:0]    w_drop_vec;
   logic [N-1:0]    w_pend_nxt;
   logic [PCW-1:0]  w_drop_num;
   logic [SW-1:0]   w_drop_sum;
   logic [CNTW-1:0] w_drop_nxt;

   // The encoder result may only be taken when the grant register is free or being emptied.
   assign w_handshake = r_gnt_vld & i_gnt_ready;
   assign w_window    = (r_state == S_IDLE) | w_handshake;
   assign w_in_range  = ({1'b0, i_enc_in} < LP_N);
   assign w_is_pend   = w_in_range & r_pend[i_enc_in];
   assign w_capture   = i_enc_valid & w_is_pend & w_window;
   assign w_bad_enc   = i_enc_valid & ~w_is_pend & w_window;

   assign w_clr      = w_capture ? (N'(1) << i_enc_in) : '0;
   assign w_kept     = r_pend & ~w_clr;
   assign w_drop_vec = i_req_in & w_kept;
   assign w_pend_nxt = w_kept | i_req_in;

   always_comb begin
      w_drop_num = '0;
      for (int b = 0; b < N; b++) begin
         w_drop_num = w_drop_num + PCW'(w_drop_vec[b]);
      end
   end

   assign w_drop_sum = SW'(r_drop_cnt) + SW'(w_drop_num);
   assign w_drop_nxt = (|w_drop_sum[SW-1:CNTW]) ? {CNTW{1'b1}} : w_drop_sum[CNTW-1:0];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend     <= '0;
         r_drop_cnt <= '0;
         r_err      <= 1'b0;
      end else if (i_flush) begin
         r_pend     <= '0;
         r_drop_cnt <= '0;
         r_err      <= 1'b0;
      end else begin
         r_pend     <= w_pend_nxt;
         r_drop_cnt <= w_drop_nxt;
         if (w_bad_enc) begin
            r_err <= 1'b1;
         end
      end
   end

   // Flush keeps the last granted index so downstream debug still sees it.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= S_IDLE;
         r_gnt_vld <= 1'b0;
         r_gnt_idx <= '0;
      end else if (i_flush) begin
         r_state   <= S_IDLE;
         r_gnt_vld <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_capture) begin
                  r_state   <= S_HOLD;
                  r_gnt_vld <= 1'b1;
                  r_gnt_idx <= i_enc_in;
               end
            end
            S_HOLD: begin
               if (w_handshake) begin
                  if (w_capture) begin
                     r_gnt_idx <= i_enc_in;
                  end else begin
                     r_state   <= S_IDLE;
                     r_gnt_vld <= 1'b0;
                  end
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_gnt_vld <= 1'b0;
            end
         endcase
      end
   end

   assign o_pend_req  = r_pend;
   assign o_gnt_valid = r_gnt_vld;
   assign o_gnt_idx   = r_gnt_idx;
   assign o_busy      = (|r_pend) | r_gnt_vld;
   assign o_drop_cnt  = r_drop_cnt;
   assign o_err       = r_err;

endmodule

// File: tb/tb_req_pending_latch.sv
// Bench for req_pending_latch with a highest-set-bit encoder stub, a bit-set reference model,
// directed scenarios pinned by literal values, and a randomized soak.
module tb_req_pending_latch;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_flush = 1'b0;
   logic [7:0] i_req_in = '0;
   logic [7:0] o_pend_req;
   logic [2:0] i_enc_in;
   logic       i_enc_valid;
   logic       o_gnt_valid;
   logic [2:0] o_gnt_idx;
   logic       i_gnt_ready = 1'b0;
   logic       o_busy;
   logic [7:0] o_drop_cnt;
   logic       o_err;

   // encoder override used to inject illegal or non-priority indices
   logic       f_en = 1'b0;
   logic       f_v  = 1'b0;
   logic [2:0] f_i  = '0;
   logic       stub_v;
   logic [2:0] stub_i;

   int checks = 0;
   int errors = 0;
   int dut_served[$];

   // reference model state
   bit [7:0] m_pend = '0;
   bit       m_gv   = 1'b0;
   int       m_gidx = 0;
   int       m_drop = 0;
   bit       m_err  = 1'b0;

   always #5 i_clk = ~i_clk;

   always_comb begin
      stub_v = |o_pend_req;
      stub_i = '0;
      for (int b = 0; b < 8; b++) begin
         if (o_pend_req[b]) stub_i = 3'(b);
      end
   end

   assign i_enc_valid = f_en ? f_v : stub_v;
   assign i_enc_in    = f_en ? f_i : stub_i;

   req_pending_latch #(.N(8), .IDXW(3), .CNTW(8)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_flush     (i_flush),
      .i_req_in    (i_req_in),
      .o_pend_req  (o_pend_req),
      .i_enc_in    (i_enc_in),
      .i_enc_valid (i_enc_valid),
      .o_gnt_valid (o_gnt_valid),
      .o_gnt_idx   (o_gnt_idx),
      .i_gnt_ready (i_gnt_ready),
      .o_busy      (o_busy),
      .o_drop_cnt  (o_drop_cnt),
      .o_err       (o_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_served(input string name, input int pos, input int exp);
      chk(name, (pos < dut_served.size()) ? dut_served[pos] : -1, exp);
   endtask

   function automatic int top_bit(input bit [7:0] p);
      for (int b = 7; b >= 0; b--) begin
         if (p[b]) return b;
      end
      return -1;
   endfunction

   // Advance the model by one clock using the inputs currently applied.
   task automatic model_step();
      int       ei;
      bit       ev, hs, window, ok, cap, served;
      int       drops;
      bit [7:0] nxt;
      if (!i_rst_n) begin
         m_pend = '0; m_gv = 0; m_gidx = 0; m_drop = 0; m_err = 0;
         return;
      end
      if (i_flush) begin
         m_pend = '0; m_gv = 0; m_drop = 0; m_err = 0;
         return;
      end
      if (f_en) begin
         ev = f_v; ei = int'(f_i);
      end else begin
         ei = top_bit(m_pend); ev = (ei >= 0);
      end
      hs     = m_gv && i_gnt_ready;
      window = !m_gv || hs;
      ok     = ev && (ei >= 0) && (ei < 8) && m_pend[ei];
      cap    = ok && window;
      if (ev && window && !ok) m_err = 1;
      drops = 0;
      for (int b = 0; b < 8; b++) begin
         served = cap && (ei == b);
         if (i_req_in[b] && m_pend[b] && !served) drops++;
         nxt[b] = i_req_in[b] || (m_pend[b] && !served);
      end
      m_pend = nxt;
      m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
      if (cap) begin
         m_gv = 1; m_gidx = ei;
      end else if (hs) begin
         m_gv = 0;
      end
   endtask

   task automatic compare_all();
      chk("pend_req",  o_pend_req,  m_pend);
      chk("gnt_valid", o_gnt_valid, m_gv);
      chk("gnt_idx",   o_gnt_idx,   m_gidx);
      chk("busy",      o_busy,      (m_pend != 0) || m_gv);
      chk("drop_cnt",  o_drop_cnt,  m_drop);
      chk("err",       o_err,       m_err);
   endtask

   // Called just after a falling edge: apply inputs, log handshakes, step model, compare at next fall.
   task automatic tick(input logic [7:0] req, input logic rdy, input logic fl);
      i_req_in    = req;
      i_gnt_ready = rdy;
      i_flush     = fl;
      #1;
      if (i_rst_n && o_gnt_valid && i_gnt_ready) dut_served.push_back(int'(o_gnt_idx));
      model_step();
      @(negedge i_clk);
      compare_all();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_pend"},  o_pend_req,  0);
      chk({tag, "_gv"},    o_gnt_valid, 0);
      chk({tag, "_idx"},   o_gnt_idx,   0);
      chk({tag, "_busy"},  o_busy,      0);
      chk({tag, "_drop"},  o_drop_cnt,  0);
      chk({tag, "_err"},   o_err,       0);
   endtask

   initial begin
      repeat (2) @(negedge i_clk);
      chk_all_zero("reset");
      i_rst_n = 1'b1;

      // single request, consumer always ready
      dut_served.delete();
      tick(8'h04, 1'b1, 1'b0);
      chk("t1_pend_c1", o_pend_req, 8'h04);
      tick(8'h00, 1'b1, 1'b0);
      chk("t1_gv_c2",  o_gnt_valid, 1);
      chk("t1_idx_c2", o_gnt_idx,   2);
      tick(8'h00, 1'b1, 1'b0);
      chk("t1_gv_c3",   o_gnt_valid, 0);
      chk("t1_busy_c3", o_busy,      0);

      // three requests, consumer stalls then drains back-to-back
      dut_served.delete();
      tick(8'h91, 1'b0, 1'b0);
      tick(8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         tick(8'h00, 1'b0, 1'b0);
         chk("t2_hold_idx", o_gnt_idx,   7);
         chk("t2_hold_gv",  o_gnt_valid, 1);
      end
      tick(8'h00, 1'b1, 1'b0);
      chk("t2_idx4", o_gnt_idx, 4);
      chk("t2_gv4",  o_gnt_valid, 1);
      tick(8'h00, 1'b1, 1'b0);
      chk("t2_idx0", o_gnt_idx, 0);
      chk("t2_gv0",  o_gnt_valid, 1);
      tick(8'h00, 1'b1, 1'b0);
      chk("t2_pend_end", o_pend_req, 8'h00);
      chk("t2_n", dut_served.size(), 3);
      chk_served("t2_g0", 0, 7);
      chk_served("t2_g1", 1, 4);
      chk_served("t2_g2", 2, 0);

      // repeated request while its bit is still pending behind a held grant
      dut_served.delete();
      tick(8'h20, 1'b0, 1'b0);
      tick(8'h02, 1'b0, 1'b0);
      tick(8'h02, 1'b0, 1'b0);
      chk("t3_drop", o_drop_cnt, 1);
      tick(8'h00, 1'b1, 1'b0);
      tick(8'h00, 1'b1, 1'b0);
      tick(8'h00, 1'b1, 1'b0);
      chk("t3_n", dut_served.size(), 2);
      chk_served("t3_g0", 0, 5);
      chk_served("t3_g1", 1, 1);

      // request on the held index during its handshake re-pends
      dut_served.delete();
      tick(8'h08, 1'b0, 1'b0);
      tick(8'h00, 1'b0, 1'b0);
      chk("t4_idx", o_gnt_idx, 3);
      tick(8'h08, 1'b1, 1'b0);
      chk("t4_repend", o_pend_req, 8'h08);
      tick(8'h00, 1'b1, 1'b0);
      chk("t4_gv2",  o_gnt_valid, 1);
      chk("t4_idx2", o_gnt_idx,   3);
      tick(8'h00, 1'b1, 1'b0);
      chk("t4_n", dut_served.size(), 2);
      chk_served("t4_g0", 0, 3);
      chk_served("t4_g1", 1, 3);
      chk("t4_drop", o_drop_cnt, 1);

      // encoder reports an index that is not pending
      f_en = 1'b1; f_v = 1'b1; f_i = 3'd5;
      tick(8'h00, 1'b0, 1'b0);
      chk("t5_err", o_err, 1);
      chk("t5_gv",  o_gnt_valid, 0);
      f_en = 1'b0;
      tick(8'h00, 1'b0, 1'b1);
      chk("t5_err_flush",  o_err,      0);
      chk("t5_drop_flush", o_drop_cnt, 0);

      // saturate the drop counter, then reset asynchronously while holding a grant
      tick(8'h80, 1'b0, 1'b0);
      tick(8'h01, 1'b0, 1'b0);
      for (int k = 0; k < 39; k++) tick(8'hFF, 1'b0, 1'b0);
      chk("t6_drop_sat", o_drop_cnt, 255);
      chk("t6_hold",     o_gnt_valid, 1);
      i_rst_n = 1'b0;
      #1;
      chk_all_zero("t6_async");
      model_step();
      tick(8'h00, 1'b0, 1'b0);
      i_rst_n = 1'b1;

      // randomized soak against the model
      for (int n = 0; n < 3000; n++) begin
         f_en = ($urandom_range(0, 15) == 0);
         f_v  = 1'($urandom_range(0, 1));
         f_i  = 3'($urandom_range(0, 7));
         i_rst_n = ($urandom_range(0, 499) != 0);
         tick(($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
              ($urandom_range(0, 2) != 0),
              ($urandom_range(0, 99) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
